// File: rtl/sa_pkg.sv
// sa_pkg: shared types and constants for the sa_tile systolic GEMM tile.
//   sa_state_t       job FSM states
//   DEF_*            default parameter values
//   sa_rows_w()      width of a row index for an N-row array (ROWW)
//   sa_flush_len()   cycles needed to push the last beat to the far PE (FLUSH_LEN)
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } sa_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ACC   = 32;
    localparam int DEF_N     = 4;
    localparam int DEF_KW    = 16;

    function automatic int sa_rows_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Beat t reaches PE[N-1][N-1] on en-edge t+2N-2, so the last beat
    // needs 2N-2 extra enabled edges after it is accepted.
    function automatic int sa_flush_len(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/sa_if.sv
// sa_if: operand/result stream bundle between the fetch unit (master) and
// the sa_tile array (slave).
//   start, k_len          job request; k_len is the number of operand beats
//   in_valid/in_ready     operand beat stream, a_in[i]=A[i][t], b_in[j]=B[t][j]
//   out_valid/out_ready   result row stream, out_data[j]=C[out_row][j]
//   busy, done            job status; done pulses once per finished job
//   dbg_state             current FSM state, for observation only
//
// Handshake rule (both streams): a transfer happens on a rising clock edge
// where valid && ready are both high. The producer holds its payload stable
// while valid is high and ready is low; ready never depends on valid.
interface sa_if
    import sa_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC   = DEF_ACC,
    parameter int KW    = DEF_KW
);
    localparam int ROWW = sa_rows_w(N);

    logic                      start;
    logic [KW-1:0]             k_len;
    logic                      in_valid;
    logic                      in_ready;
    logic [N-1:0][WIDTH-1:0]   a_in;
    logic [N-1:0][WIDTH-1:0]   b_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [ROWW-1:0]           out_row;
    logic [N-1:0][ACC-1:0]     out_data;
    logic                      busy;
    logic                      done;
    sa_state_t                 dbg_state;

    modport master (
        output start, k_len, in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_row, out_data, busy, done, dbg_state
    );

    modport slave (
        input  start, k_len, in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, out_row, out_data, busy, done, dbg_state
    );

endinterface

// File: rtl/sa_pe_clr.sv
// sa_pe_clr: one output-stationary processing element.
//   clk, rst_n   clock, asynchronous active-low reset
//   en           advance: accumulate and forward operands
//   clr          synchronous clear of accumulator and forwarding registers
//   a_in, b_in   signed operands arriving from the left / top
//   a_out, b_out operands forwarded right / down, one en-edge later
//   acc          running signed sum of a*b, wraps modulo 2^ACC
module sa_pe_clr #(
    parameter int WIDTH = 8,
    parameter int ACC   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [ACC-1:0]   acc
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC-1:0]     prod_ext;

    assign prod     = $signed(a_in) * $signed(b_in);
    // Size cast of a signed value sign-extends the full-width product.
    assign prod_ext = ACC'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (clr) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (en) begin
            acc   <= acc + prod_ext;
            a_out <= a_in;
            b_out <= b_in;
        end
    end

endmodule

// File: rtl/sa_tile.sv
// sa_tile: NxN output-stationary signed systolic GEMM tile, C = A x B with
// runtime K. Operands stream in one beat per accepted handshake, are skewed
// so PE[i][j] sees beat t on en-edge t+i+j, then the array is flushed with
// zeros and the result rows are streamed out one per handshake.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          sa_if slave: job control, operand stream, result stream
module sa_tile
    import sa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC   = DEF_ACC,
    parameter int N     = DEF_N,
    parameter int KW    = DEF_KW
) (
    input logic  clk,
    input logic  rst_n,
    sa_if.slave  bus
);

    localparam int ROWW      = sa_rows_w(N);
    localparam int FLUSH_LEN = sa_flush_len(N);
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    sa_state_t       state, state_nx;
    logic [KW-1:0]   k_reg;
    logic [KW-1:0]   beat_cnt;
    logic [FW-1:0]   flush_cnt;
    logic [ROWW-1:0] row_cnt;
    logic            en;
    logic            clr;
    logic            job_go;
    logic            last_row_take;

    assign job_go        = (state == IDLE) && bus.start && (bus.k_len != '0);
    assign last_row_take = (state == DRAIN) && bus.out_ready &&
                           (row_cnt == ROWW'(N - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        en       = 1'b0;
        clr      = 1'b0;
        case (state)
            IDLE: begin
                if (job_go) begin
                    clr      = 1'b1;
                    state_nx = FEED;
                end
            end
            FEED: begin
                en = bus.in_valid && bus.in_ready;
                if (en && (beat_cnt == k_reg - 1'b1)) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                en = 1'b1;
                if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (last_row_take) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- counters and done ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_cnt   <= '0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= last_row_take;
            case (state)
                IDLE: begin
                    if (job_go) begin
                        k_reg     <= bus.k_len;
                        beat_cnt  <= '0;
                        flush_cnt <= '0;
                        row_cnt   <= '0;
                    end
                end
                FEED:  if (en) beat_cnt <= beat_cnt + 1'b1;
                FLUSH: flush_cnt <= flush_cnt + 1'b1;
                DRAIN: begin
                    if (bus.out_ready) begin
                        row_cnt <= last_row_take ? '0 : row_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- input skew ----------------
    // Outside FEED the sources are forced to zero, which is what FLUSH
    // injects; during FEED with in_valid low en is 0, so nothing moves.
    logic [WIDTH-1:0] a_src  [N];
    logic [WIDTH-1:0] b_src  [N];
    logic [WIDTH-1:0] a_edge [N];
    logic [WIDTH-1:0] b_edge [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_src[i] = (state == FEED) ? bus.a_in[i] : '0;
            b_src[i] = (state == FEED) ? bus.b_in[i] : '0;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_src[gi];
            assign b_edge[gi] = b_src[gi];
        end else begin : g_pipe
            // Row/column gi is delayed by gi enabled stages.
            logic [WIDTH-1:0] a_pipe [gi];
            logic [WIDTH-1:0] b_pipe [gi];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < gi; s++) begin
                        a_pipe[s] <= '0;
                        b_pipe[s] <= '0;
                    end
                end else if (clr) begin
                    for (int s = 0; s < gi; s++) begin
                        a_pipe[s] <= '0;
                        b_pipe[s] <= '0;
                    end
                end else if (en) begin
                    a_pipe[0] <= a_src[gi];
                    b_pipe[0] <= b_src[gi];
                    for (int s = 1; s < gi; s++) begin
                        a_pipe[s] <= a_pipe[s-1];
                        b_pipe[s] <= b_pipe[s-1];
                    end
                end
            end
            assign a_edge[gi] = a_pipe[gi-1];
            assign b_edge[gi] = b_pipe[gi-1];
        end
    end

    // ---------------- PE grid ----------------
    logic [WIDTH-1:0] a_h     [N][N+1];
    logic [WIDTH-1:0] b_v     [N+1][N];
    logic [ACC-1:0]   acc_arr [N][N];
    // Operands leaving the right/bottom edge have no consumer.
    logic [WIDTH-1:0] a_unused [N];
    logic [WIDTH-1:0] b_unused [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_edges
        assign a_h[gi][0]   = a_edge[gi];
        assign b_v[0][gi]   = b_edge[gi];
        assign a_unused[gi] = a_h[gi][N];
        assign b_unused[gi] = b_v[N][gi];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            sa_pe_clr #(.WIDTH(WIDTH), .ACC(ACC)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .clr   (clr),
                .a_in  (a_h[gi][gj]),
                .b_in  (b_v[gi][gj]),
                .a_out (a_h[gi][gj+1]),
                .b_out (b_v[gi+1][gj]),
                .acc   (acc_arr[gi][gj])
            );
        end
    end

    // ---------------- outputs ----------------
    assign bus.in_ready  = (state == FEED);
    assign bus.out_valid = (state == DRAIN);
    assign bus.busy      = (state != IDLE);
    assign bus.out_row   = row_cnt;
    assign bus.dbg_state = state;

    // row_cnt only changes on a consumed row, so the presented row is
    // stable under backpressure.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            bus.out_data[j] = (state == DRAIN) ? acc_arr[row_cnt][j] : '0;
        end
    end

endmodule

// File: tb/tb_sa_tile.sv
module tb_sa_tile;
    import sa_pkg::*;

    localparam int WIDTH = 8;
    localparam int ACC   = 32;
    localparam int KW    = 16;
    localparam int KMAX  = 8;
    localparam int W     = 4 * ACC;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs (N=2 and N=4) ----------------
    sa_if #(.N(2), .WIDTH(WIDTH), .ACC(ACC), .KW(KW)) bus2 ();
    sa_if #(.N(4), .WIDTH(WIDTH), .ACC(ACC), .KW(KW)) bus4 ();

    sa_tile #(.WIDTH(WIDTH), .ACC(ACC), .N(2), .KW(KW)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    sa_tile #(.WIDTH(WIDTH), .ACC(ACC), .N(4), .KW(KW)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    logic                    sel4;
    logic                    start, in_valid, out_ready;
    logic [KW-1:0]           k_len;
    logic [3:0][WIDTH-1:0]   a_drv, b_drv;

    assign bus2.start     = start && !sel4;
    assign bus4.start     = start && sel4;
    assign bus2.k_len     = k_len;
    assign bus4.k_len     = k_len;
    assign bus2.in_valid  = in_valid && !sel4;
    assign bus4.in_valid  = in_valid && sel4;
    assign bus2.a_in      = a_drv[1:0];
    assign bus2.b_in      = b_drv[1:0];
    assign bus4.a_in      = a_drv;
    assign bus4.b_in      = b_drv;
    assign bus2.out_ready = out_ready;
    assign bus4.out_ready = out_ready;

    logic            cur_in_ready, cur_out_valid, cur_busy, cur_done;
    logic [1:0]      cur_row;
    logic [W-1:0]    cur_data;

    always_comb begin
        if (sel4) begin
            cur_in_ready  = bus4.in_ready;
            cur_out_valid = bus4.out_valid;
            cur_busy      = bus4.busy;
            cur_done      = bus4.done;
            cur_row       = bus4.out_row;
            cur_data      = bus4.out_data;
        end else begin
            cur_in_ready  = bus2.in_ready;
            cur_out_valid = bus2.out_valid;
            cur_busy      = bus2.busy;
            cur_done      = bus2.done;
            cur_row       = {1'b0, bus2.out_row};
            cur_data      = {64'd0, bus2.out_data};
        end
    end

    // ---------------- scoreboard ----------------
    int           ga [4][KMAX];
    int           gb [KMAX][4];
    logic [W-1:0] exp_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic push_golden(input int n, input int k);
        logic [W-1:0] row;
        int s;
        for (int i = 0; i < n; i++) begin
            row = '0;
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int t = 0; t < k; t++) s += ga[i][t] * gb[t][j];
                row[j*ACC +: ACC] = s;
            end
            exp_q.push_back(row);
        end
    endtask

    task automatic fill_random(input int k);
        for (int i = 0; i < 4; i++)
            for (int t = 0; t < KMAX; t++) begin
                ga[i][t] = int'($urandom_range(255)) - 128;
                gb[t][i] = int'($urandom_range(255)) - 128;
            end
        if (k > KMAX) $display("[TB] k too large");
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int i = 0; i < 4; i++)
            for (int t = 0; t < KMAX; t++) begin
                ga[i][t] = av;
                gb[t][i] = bv;
            end
    endtask

    // ---------------- driver: one full job ----------------
    task automatic run_job(input int k, input int stall_pct, input bit bp,
                           input bit chk_lat, input bit no_wait);
        int n, t, rows, waits, lat0, bp_left;
        bit v, accept, seen;
        logic [W-1:0] exp;
        n = sel4 ? 4 : 2;
        push_golden(n, k);
        if (!no_wait) @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat0  = cyc;
        n_tests++;
        if (cur_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b want 1", cur_busy);
        end
        t = 0;
        waits = 0;
        while (t < k && waits < 500) begin
            @(negedge clk);
            waits++;
            if (waits == 1) begin
                n_tests++;
                if (cur_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_width: got %b want 0", cur_done);
                end
            end
            v = ($urandom_range(99) >= stall_pct);
            in_valid = v;
            for (int i = 0; i < 4; i++) begin
                if (v) begin
                    a_drv[i] = (i < n) ? WIDTH'(ga[i][t]) : '0;
                    b_drv[i] = (i < n) ? WIDTH'(gb[t][i]) : '0;
                end else begin
                    a_drv[i] = WIDTH'($urandom_range(255));
                    b_drv[i] = WIDTH'($urandom_range(255));
                end
            end
            accept = v && cur_in_ready;
            @(posedge clk);
            if (accept) t++;
        end
        if (t < k) begin
            n_tests++;
            n_fail++;
            $display("FAIL feed_timeout: accepted %0d want %0d", t, k);
        end
        #1 in_valid = 1'b0;
        rows = 0;
        waits = 0;
        seen = 1'b0;
        bp_left = bp ? 3 : 0;
        while (rows < n && waits < 500) begin
            @(negedge clk);
            waits++;
            if (cur_out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (chk_lat) begin
                        n_tests++;
                        if (cyc - lat0 != k + 2 * n - 2) begin
                            n_fail++;
                            $display("FAIL latency: got %0d want %0d", cyc - lat0, k + 2 * n - 2);
                        end
                    end
                end
                if (bp_left > 0) begin
                    out_ready = 1'b0;
                    bp_left--;
                    n_tests++;
                    if (cur_row !== 2'd0 || cur_data !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL bp_hold: row %0d data %h want row 0 data %h", cur_row, cur_data, exp_q[0]);
                    end
                end else begin
                    out_ready = 1'b1;
                    exp = exp_q.pop_front();
                    n_tests++;
                    if (cur_row !== 2'(rows) || cur_data !== exp) begin
                        n_fail++;
                        $display("FAIL row_data: row %0d data %h want row %0d data %h", cur_row, cur_data, rows, exp);
                    end
                    rows++;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
        if (rows < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: rows %0d want %0d", rows, n);
            exp_q.delete();
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (cur_done !== 1'b1 || cur_out_valid !== 1'b0 || cur_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done %b out_valid %b busy %b want 1 0 0", cur_done, cur_out_valid, cur_busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic check_reset_vals(input string tag);
        n_tests++;
        if (bus2.in_ready !== 1'b0 || bus2.out_valid !== 1'b0 || bus2.out_row !== '0 ||
            bus2.out_data !== '0 || bus2.busy !== 1'b0 || bus2.done !== 1'b0 ||
            bus2.dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL %s_n2: rdy %b ov %b row %0d data %h busy %b done %b want all 0",
                     tag, bus2.in_ready, bus2.out_valid, bus2.out_row, bus2.out_data, bus2.busy, bus2.done);
        end
        n_tests++;
        if (bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b0 || bus4.out_row !== '0 ||
            bus4.out_data !== '0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0 ||
            bus4.dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL %s_n4: rdy %b ov %b row %0d data %h busy %b done %b want all 0",
                     tag, bus4.in_ready, bus4.out_valid, bus4.out_row, bus4.out_data, bus4.busy, bus4.done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        sel4 = 1'b0;
        fill_const(0, 0);
        ga[0][0] = 1; ga[0][1] = 2; ga[1][0] = 3; ga[1][1] = 4;
        gb[0][0] = 1; gb[1][1] = 1;
        run_job(2, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_extremes();
        sel4 = 1'b0;
        fill_const(-128, -128);
        run_job(1, 0, 1'b0, 1'b1, 1'b0);
        fill_const(127, -128);
        run_job(3, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stalls();
        sel4 = 1'b1;
        fill_random(4);
        run_job(4, 0, 1'b0, 1'b1, 1'b0);
        run_job(4, 40, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        sel4 = 1'b1;
        fill_random(5);
        run_job(5, 0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        sel4 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(2);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a_drv = {8'd0, 8'd0, 8'd7, 8'd9};
        b_drv = {8'd0, 8'd0, 8'd3, 8'd2};
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        fill_const(0, 0);
        ga[0][0] = 5; ga[1][1] = 5;
        gb[0][0] = 1; gb[1][1] = 1;
        run_job(2, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel4 = 1'b0;
        fill_random(3);
        run_job(3, 0, 1'b0, 1'b1, 1'b0);
        fill_random(2);
        run_job(2, 0, 1'b0, 1'b1, 1'b1);
        sel4 = 1'b1;
        fill_random(6);
        run_job(6, 20, 1'b0, 1'b0, 1'b0);
        fill_random(1);
        run_job(1, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_klen_zero();
        sel4 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        k_len = '0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (cur_busy !== 1'b0 || cur_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL klen_zero: busy %b in_ready %b want 0 0", cur_busy, cur_in_ready);
            end
        end
    endtask

    // ---------------- main ----------------
    initial begin
        sel4 = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        k_len = '0;
        a_drv = '0;
        b_drv = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_stalls();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_klen_zero();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d rows never delivered, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
